// File: rtl/arb4_rr_ctrl_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding
//   NUM_REQ     : number of requesters
//   SEL_W       : width of a requester index / mux select
//   rr_pick     : round-robin winner search starting after the last winner
//   idx_onehot  : requester index to one-hot grant vector
package arb4_rr_ctrl_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANTED
  } arb_state_e;

  // Search order ptr+1, ptr+2, ptr+3, ptr. Walking the offsets from highest to
  // lowest lets the last hit be the highest-priority requester.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pick;
    pick = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arb4_rr_ctrl_mux4x1.sv
// 4:1 combinational data multiplexer for the shared arbiter port.
//   WIDTH : data width
//   sel   : input select, 0 picks IN_1 ... 3 picks IN_4
//   IN_1..IN_4 : data inputs
//   OUT   : selected data
module mux4X1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] IN_1,
  input  logic [WIDTH-1:0] IN_2,
  input  logic [WIDTH-1:0] IN_3,
  input  logic [WIDTH-1:0] IN_4,
  output logic [WIDTH-1:0] OUT
);

  always_comb begin
    OUT = IN_1;
    unique case (sel)
      2'd0: OUT = IN_1;
      2'd1: OUT = IN_2;
      2'd2: OUT = IN_3;
      2'd3: OUT = IN_4;
      default: OUT = IN_1;
    endcase
  end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit datapath port among four
// requesters. A grant is held until DONE, until the granted requester drops its
// request, or (watchdog build) until it has been held TIMEOUT cycles.
// Optional feature macro: ARB_TIMEOUT_EN builds the watchdog and TIMEOUT_ERR.
//   CLK, RST    : clock, synchronous active-high reset
//   REQ[3:0]    : level requests, bit i belongs to IN_(i+1)
//   DONE        : completion strobe of the shared resource
//   IN_1..IN_4  : requester data
//   OUT         : data of requester SEL (combinational)
//   GNT[3:0]    : registered one-hot grant, zero when idle
//   SEL[1:0]    : registered index of the current or last grant
//   BUSY        : registered, high while a grant is held
//   TIMEOUT_ERR : registered one-cycle pulse after a forced release
import arb4_rr_ctrl_pkg::*;

module arb4_rr_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               DONE,
  input  logic [WIDTH-1:0]   IN_1,
  input  logic [WIDTH-1:0]   IN_2,
  input  logic [WIDTH-1:0]   IN_3,
  input  logic [WIDTH-1:0]   IN_4,
  output logic [WIDTH-1:0]   OUT,
  output logic [NUM_REQ-1:0] GNT,
  output logic [SEL_W-1:0]   SEL,
  output logic               BUSY,
  output logic               TIMEOUT_ERR
);

  arb_state_e       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic             any_req;
  logic             granted_req;
  logic             wd_expire;
  logic             release_now;

  // PTR already holds the current winner, so this also serves the re-evaluation
  // on release.
  assign win         = rr_pick(REQ, ptr);
  assign any_req     = |REQ;
  assign granted_req = REQ[SEL];
  assign release_now = DONE | ~granted_req | wd_expire;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wd_cnt;

  // wd_cnt counts completed cycles of the current grant, so the edge ending the
  // TIMEOUT-th cycle sees TIMEOUT-1.
  assign wd_expire = (state == ARB_GRANTED) && (wd_cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt      <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      // A forced release only when nothing else would have released the grant.
      TIMEOUT_ERR <= wd_expire & ~DONE & granted_req;
      if ((state != ARB_GRANTED) || release_now) begin
        wd_cnt <= '0;
      end else if (wd_cnt != {CntW{1'b1}}) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ARB_IDLE;
      ptr   <= SEL_W'(NUM_REQ - 1);
      GNT   <= '0;
      SEL   <= '0;
      BUSY  <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          // SEL is held here so OUT stays on the last granted input.
          if (any_req) begin
            state <= ARB_GRANTED;
            ptr   <= win;
            GNT   <= idx_onehot(win);
            SEL   <= win;
            BUSY  <= 1'b1;
          end
        end
        ARB_GRANTED: begin
          if (release_now) begin
            if (any_req) begin
              // Back-to-back grant; the sole requester may win again.
              ptr  <= win;
              GNT  <= idx_onehot(win);
              SEL  <= win;
              BUSY <= 1'b1;
            end else begin
              state <= ARB_IDLE;
              GNT   <= '0;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ARB_IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  mux4X1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel (SEL),
    .IN_1(IN_1),
    .IN_2(IN_2),
    .IN_3(IN_3),
    .IN_4(IN_4),
    .OUT (OUT)
  );

endmodule

// File: doc/arb4_rr_ctrl.md
# arb4_rr_ctrl

Round-robin arbiter and sequencer that shares one 4-input, WIDTH-bit datapath port among four requesters in the pipelined MIPS core, e.g. a shared memory or writeback port. It owns the 2-bit select of an internal 4:1 multiplexer and holds a grant until the serviced resource signals completion. An optional watchdog revokes a grant that is held too long.

## Interface
- WIDTH, 32, data width of each requester input and of OUT
- TIMEOUT, 15, maximum number of consecutive cycles one grant may be held (watchdog build only); legal range 2..255
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  synchronous, active-high reset
- REQ  input  4  per-requester request, level; bit i belongs to IN_(i+1)
- DONE  input  1  resource completion strobe; meaningful only while BUSY=1
- IN_1..IN_4  input  WIDTH each  requester data
- OUT  output  WIDTH  selected requester data (combinational from SEL)
- GNT  output  4  one-hot grant, registered; all zero when idle
- SEL  output  2  registered mux select, the index of the current or last grant
- BUSY  output  1  registered; 1 while a grant is held
- TIMEOUT_ERR  output  1  registered single-cycle pulse on a forced release

## Operation
- The FSM has two states.
  - IDLE: GNT=0, BUSY=0.
  - GRANTED: exactly one GNT bit is set, BUSY=1.
- Priority pointer PTR holds the index of the last winner. The search order is PTR+1, PTR+2, PTR+3, PTR (mod 4). The last winner therefore has the lowest priority but can win again if it is the only requester.
- IDLE with any REQ set: choose the winner, load GNT/SEL with it, set PTR to the winner index, go to GRANTED. With no REQ: stay in IDLE and hold SEL.
- GRANTED: the grant is released on the first of these events:
  - DONE=1
  - REQ of the granted requester drops to 0 (abort)
  - watchdog expiry
- On release, REQ is re-evaluated in the same cycle with the updated PTR.
  - If another requester is waiting, the next grant starts on the next cycle (back-to-back, no idle gap).
  - Otherwise the FSM goes to IDLE.
- SEL is never changed in IDLE, so OUT stays stable on the last granted input.
- OUT = IN_(SEL+1), combinational, with no added latency.
- Simultaneous events:
  - DONE together with watchdog expiry: counts as a normal completion; TIMEOUT_ERR stays 0.
  - DONE together with an abort: a single release.
  - REQ changes on non-granted bits during GRANTED: ignored until the next release.
- Reset values: GNT=4'b0000, SEL=2'b00, BUSY=0, TIMEOUT_ERR=0, PTR=3 (requester 0 has first priority), watchdog count=0, state IDLE. OUT therefore equals IN_1.
- RST asserted mid-grant: all of the above values apply after that edge. DONE is ignored in that cycle.

## Timing
- Request to grant: REQ sampled at edge N, GNT/SEL/BUSY valid after edge N (1 cycle).
- DONE sampled at edge M releases the grant. After edge M, GNT shows either the next winner or zero.
- Watchdog: the count starts at 0 on every new grant and increments on each GRANTED cycle without DONE. If the grant is still held at the edge ending its TIMEOUT-th cycle, the release is forced and TIMEOUT_ERR=1 for exactly the following cycle.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- Maximum wait for any requester that holds REQ: 3 grants (fairness bound).

## Configuration
- ARB_TIMEOUT_EN defined: the watchdog counter and TIMEOUT_ERR logic are built as described above.
- ARB_TIMEOUT_EN undefined: no counter is built, TIMEOUT_ERR is tied to 0, and a grant is held until DONE or abort with no time limit. TIMEOUT is ignored.

## Structure
- Shared package contents:
  - state encoding typedef (ARB_IDLE, ARB_GRANTED)
  - requester count constant NUM_REQ=4
  - index width constant SEL_W=2
- One sub-module: mux4X1, instantiated with WIDTH, sel=SEL, IN_1..IN_4 passed through, driving OUT.
- The arbiter FSM, PTR, next-winner logic and watchdog live in arb4_rr_ctrl itself.

## Test plan
- Reset then REQ=4'b1111: grants go 0,1,2,3,0 in that order, each released by a one-cycle DONE; GNT is 0001,0010,0100,1000,0001 with no idle cycle between grants.
- REQ=4'b0100 only, DONE after 3 cycles: GNT=0100 and SEL=2 for 3 cycles, OUT=IN_3, then GNT=0100 again on the next cycle (sole requester re-wins).
- Granted requester 1 drops REQ without DONE while REQ[3]=1: GNT moves to 1000 on the next cycle and TIMEOUT_ERR stays 0.
- ARB_TIMEOUT_EN defined, TIMEOUT=4, REQ[0] held, no DONE: GNT=0001 for exactly 4 cycles, then TIMEOUT_ERR=1 for one cycle. Repeat with DONE in the 4th cycle: TIMEOUT_ERR stays 0.
- RST asserted in the 2nd cycle of a grant to requester 2: after that edge GNT=0, SEL=0, BUSY=0, OUT=IN_1, and with REQ=4'b1111 the next grant goes to requester 0.
